// File: rtl/multicore_pkg.sv
// -----------------------------------------------------------------------------
// multicore_pkg
// Shared types and constants for the per-core ALU issue path.
//   DATA_SIZE    : operand/result width (32 only)
//   t_aluop      : ALU function code driven into the execute ALU
//   OPC_*        : RV32I major opcodes decoded by the operand stage
//   t_alu_issue  : payload issued to the ALU {funct, op_a, op_b, rd, wr_en, illegal}
// -----------------------------------------------------------------------------
package multicore_pkg;

    localparam int DATA_SIZE = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } t_aluop;

    typedef struct packed {
        t_aluop                 funct;
        logic [DATA_SIZE-1:0]   op_a;
        logic [DATA_SIZE-1:0]   op_b;
        logic [4:0]             rd;
        logic                   wr_en;
        logic                   illegal;
    } t_alu_issue;

    // Payload presented by an empty/reset stage and by illegal instructions
    // (illegal flag set separately).
    function automatic t_alu_issue alu_issue_idle();
        t_alu_issue r;
        r.funct   = ALU_ADD;
        r.op_a    = '0;
        r.op_b    = '0;
        r.rd      = '0;
        r.wr_en   = 1'b0;
        r.illegal = 1'b0;
        return r;
    endfunction

    // alt selects SUB on funct3=000 and SRA on funct3=101; ignored elsewhere.
    function automatic t_aluop aluop_from_funct3(logic [2:0] funct3, logic alt);
        t_aluop r;
        r = ALU_ADD;
        case (funct3)
            F3_ADD:  r = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  r = ALU_SLL;
            F3_SLT:  r = ALU_SLT;
            F3_SLTU: r = ALU_SLTU;
            F3_XOR:  r = ALU_XOR;
            F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   r = ALU_OR;
            F3_AND:  r = ALU_AND;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// -----------------------------------------------------------------------------
// alu_decode
// Purely combinational RV32I decode for the ALU issue path: selects the ALU
// function and builds both operands for OP, OP-IMM, LUI and AUIPC.
//   i_instr      : instruction word
//   i_pc         : PC of i_instr
//   i_rs1_data   : register-file read for rs1
//   i_rs2_data   : register-file read for rs2
//   o_issue      : decoded payload; illegal words yield ADD 0,0 with illegal=1
// -----------------------------------------------------------------------------
module alu_decode
    import multicore_pkg::*;
(
    input  logic [31:0]          i_instr,
    input  logic [DATA_SIZE-1:0] i_pc,
    input  logic [DATA_SIZE-1:0] i_rs1_data,
    input  logic [DATA_SIZE-1:0] i_rs2_data,
    output t_alu_issue           o_issue
);

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [4:0]           rd;
    logic                 alt;
    logic                 is_shift;
    logic [DATA_SIZE-1:0] imm_i;
    logic [DATA_SIZE-1:0] imm_u;
    logic [DATA_SIZE-1:0] shamt_reg;
    logic [DATA_SIZE-1:0] shamt_imm;
    logic                 legal;
    t_alu_issue           issue;

    assign opcode   = i_instr[6:0];
    assign rd       = i_instr[11:7];
    assign funct3   = i_instr[14:12];
    assign funct7   = i_instr[31:25];
    assign alt      = (funct7 == FUNCT7_ALT);
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

    assign imm_i     = {{(DATA_SIZE-12){i_instr[31]}}, i_instr[31:20]};
    assign imm_u     = {i_instr[31:12], 12'b0};
    // Shift amounts are masked to 5 bits so the ALU never sees an oversized shift.
    assign shamt_reg = {{(DATA_SIZE-5){1'b0}}, i_rs2_data[4:0]};
    assign shamt_imm = {{(DATA_SIZE-5){1'b0}}, i_instr[24:20]};

    always_comb begin
        issue = alu_issue_idle();
        legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal       = (funct7 == FUNCT7_BASE) ||
                              (alt && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
                issue.funct = aluop_from_funct3(funct3, alt);
                issue.op_a  = i_rs1_data;
                issue.op_b  = is_shift ? shamt_reg : i_rs2_data;
            end
            OPC_OP_IMM: begin
                // Non-shift immediates use instr[31:25] as immediate bits, so
                // only the shift forms constrain them; ADDI never becomes SUB.
                legal       = !is_shift || (funct7 == FUNCT7_BASE) ||
                              (alt && (funct3 == F3_SR));
                issue.funct = aluop_from_funct3(funct3, alt && (funct3 == F3_SR));
                issue.op_a  = i_rs1_data;
                issue.op_b  = is_shift ? shamt_imm : imm_i;
            end
            OPC_LUI: begin
                legal       = 1'b1;
                issue.funct = ALU_ADD;
                issue.op_a  = '0;
                issue.op_b  = imm_u;
            end
            OPC_AUIPC: begin
                legal       = 1'b1;
                issue.funct = ALU_ADD;
                issue.op_a  = i_pc;
                issue.op_b  = imm_u;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        if (legal) begin
            issue.rd      = rd;
            issue.wr_en   = (rd != 5'd0);
            issue.illegal = 1'b0;
        end else begin
            issue         = alu_issue_idle();
            issue.illegal = 1'b1;
        end
    end

    assign o_issue = issue;

endmodule

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
// Decode-and-issue stage feeding the execute ALU. Decodes one RV32I word and
// registers the issue payload behind a valid/ready handshake with a two-entry
// skid buffer (main/output register plus skid register).
//   i_clk, i_rst_n              : clock, async active-low reset
//   i_valid / o_ready           : upstream handshake (o_ready registered)
//   i_instr, i_pc, i_rs*_data   : instruction, PC and operand reads
//   o_valid / i_ready           : downstream handshake
//   o_funct, o_op_a, o_op_b     : ALU function and operands (registered)
//   o_rd, o_wr_en, o_illegal    : writeback target, write enable, decode fault
// -----------------------------------------------------------------------------
module alu_operand_stage
    import multicore_pkg::*;
#(
    parameter int DATA_SIZE = multicore_pkg::DATA_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [31:0]          i_instr,
    input  logic [DATA_SIZE-1:0] i_pc,
    input  logic [DATA_SIZE-1:0] i_rs1_data,
    input  logic [DATA_SIZE-1:0] i_rs2_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output t_aluop               o_funct,
    output logic [DATA_SIZE-1:0] o_op_a,
    output logic [DATA_SIZE-1:0] o_op_b,
    output logic [4:0]           o_rd,
    output logic                 o_wr_en,
    output logic                 o_illegal
);

    t_alu_issue dec_issue;

    t_alu_issue main_q, main_d;
    t_alu_issue skid_q, skid_d;
    logic       main_vld_q, main_vld_d;
    logic       skid_vld_q, skid_vld_d;
    logic       ready_q, ready_d;

    logic       in_xfer;
    logic       out_xfer;

    alu_decode u_decode (
        .i_instr    (i_instr),
        .i_pc       (i_pc),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .o_issue    (dec_issue)
    );

    assign in_xfer  = i_valid & ready_q;
    assign out_xfer = main_vld_q & i_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

        if (skid_vld_q) begin
            // ready is low, so nothing arrives; the skid entry refills main
            // as soon as main drains.
            if (out_xfer) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (!main_vld_q || out_xfer) begin
            main_vld_d = in_xfer;
            if (in_xfer) begin
                main_d = dec_issue;
            end
        end else if (in_xfer) begin
            // main is stalled downstream: park the new word in the skid slot.
            skid_d     = dec_issue;
            skid_vld_d = 1'b1;
        end

        ready_d = !skid_vld_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q     <= alu_issue_idle();
            skid_q     <= alu_issue_idle();
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            ready_q    <= ready_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = main_vld_q;
    assign o_funct   = main_q.funct;
    assign o_op_a    = main_q.op_a;
    assign o_op_b    = main_q.op_b;
    assign o_rd      = main_q.rd;
    assign o_wr_en   = main_q.wr_en;
    assign o_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
    import multicore_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_instr = 32'h0;
    logic [31:0] i_pc = 32'h0;
    logic [31:0] i_rs1_data = 32'h0;
    logic [31:0] i_rs2_data = 32'h0;
    logic        o_ready;
    logic        o_valid;
    t_aluop      o_funct;
    logic [31:0] o_op_a;
    logic [31:0] o_op_b;
    logic [4:0]  o_rd;
    logic        o_wr_en;
    logic        o_illegal;

    alu_operand_stage dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_instr    (i_instr),
        .i_pc       (i_pc),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_funct    (o_funct),
        .o_op_a     (o_op_a),
        .o_op_b     (o_op_b),
        .o_rd       (o_rd),
        .o_wr_en    (o_wr_en),
        .o_illegal  (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        t_aluop      funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [31:0] out_log[$];
    int          checks = 0;
    int          errors = 0;
    bit          last_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic t_aluop ref_fn(input int f3, input bit alt);
        case (f3)
            0: return alt ? ALU_SUB : ALU_ADD;
            1: return ALU_SLL;
            2: return ALU_SLT;
            3: return ALU_SLTU;
            4: return ALU_XOR;
            5: return alt ? ALU_SRA : ALU_SRL;
            6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int   f3 = int'(ins[14:12]);
        int   f7 = int'(ins[31:25]);
        bit   alt = (f7 == 32);
        bit   shift = (f3 == 1) || (f3 == 5);
        bit   ok = 0;
        int   imm = int'(ins[31:20]);
        if (imm >= 2048) imm = imm - 4096;
        r.funct = ALU_ADD;
        r.a = 0;
        r.b = 0;
        r.rd = ins[11:7];
        case (ins[6:0])
            7'h33: begin
                ok = (f7 == 0) || (alt && (f3 == 0 || f3 == 5));
                r.funct = ref_fn(f3, alt);
                r.a = a;
                r.b = shift ? (b % 32) : b;
            end
            7'h13: begin
                ok = !shift || (f7 == 0) || (alt && f3 == 5);
                r.funct = ref_fn(f3, alt && f3 == 5);
                r.a = a;
                r.b = shift ? 32'(ins[24:20]) : 32'(imm);
            end
            7'h37: begin
                ok = 1;
                r.a = 0;
                r.b = ins & 32'hFFFF_F000;
            end
            7'h17: begin
                ok = 1;
                r.a = pc;
                r.b = ins & 32'hFFFF_F000;
            end
            default: ok = 0;
        endcase
        if (ok) begin
            r.wr = (r.rd != 0);
            r.ill = 0;
        end else begin
            r.funct = ALU_ADD;
            r.a = 0;
            r.b = 0;
            r.rd = 0;
            r.wr = 0;
            r.ill = 1;
        end
        return r;
    endfunction

    // Called just before a rising edge: compare DUT against model, then apply
    // the handshake that this edge will perform.
    task automatic model_step();
        exp_t e;
        bit   del;
        bit   acc;
        chk("o_valid", 32'(o_valid), 32'(q.size() != 0));
        chk("o_ready", 32'(o_ready), 32'(q.size() < 2));
        if (q.size() != 0) begin
            e = q[0];
            chk("o_funct", 32'(o_funct), 32'(e.funct));
            chk("o_op_a", o_op_a, e.a);
            chk("o_op_b", o_op_b, e.b);
            chk("o_rd", 32'(o_rd), 32'(e.rd));
            chk("o_wr_en", 32'(o_wr_en), 32'(e.wr));
            chk("o_illegal", 32'(o_illegal), 32'(e.ill));
        end
        del = (q.size() != 0) && i_ready;
        acc = i_valid && (q.size() < 2);
        if (del) begin
            out_log.push_back(o_op_a);
            void'(q.pop_front());
        end
        if (acc) q.push_back(ref_decode(i_instr, i_pc, i_rs1_data, i_rs2_data));
        last_acc = acc;
    endtask

    task automatic tick();
        @(negedge i_clk);
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        i_valid = v;
        i_instr = ins;
        i_pc = pc;
        i_rs1_data = a;
        i_rs2_data = b;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        logic [6:0]  f7;
        logic [6:0]  opc;
        case ($urandom_range(0, 5))
            0: opc = 7'h33;
            1: opc = 7'h13;
            2: opc = 7'h37;
            3: opc = 7'h17;
            4: opc = 7'($urandom);
            default: opc = 7'h6F;
        endcase
        case ($urandom_range(0, 3))
            0, 1: f7 = 7'h00;
            2: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        return {f7, w[24:7], opc};
    endfunction

    initial begin
        // Reset asserted asynchronously, checked without any clock edge.
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_ready", 32'(o_ready), 32'd1);
        chk("rst_o_funct", 32'(o_funct), 32'(ALU_ADD));
        chk("rst_o_op_a", o_op_a, 32'd0);
        chk("rst_o_op_b", o_op_b, 32'd0);
        chk("rst_o_rd", 32'(o_rd), 32'd0);
        chk("rst_o_wr_en", 32'(o_wr_en), 32'd0);
        chk("rst_o_illegal", 32'(o_illegal), 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Directed decode cases with downstream always ready.
        i_ready = 1'b1;
        drive(1, 32'h002081B3, 32'h0, 32'd5, 32'd7);              // ADD x3,x1,x2
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("add_valid", 32'(o_valid), 32'd1);
        chk("add_funct", 32'(o_funct), 32'(ALU_ADD));
        chk("add_op_a", o_op_a, 32'd5);
        chk("add_op_b", o_op_b, 32'd7);
        chk("add_rd", 32'(o_rd), 32'd3);
        chk("add_wr_en", 32'(o_wr_en), 32'd1);

        drive(1, 32'h4030D213, 32'h0, 32'h8000_0000, 32'h0);       // SRAI x4,x1,3
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("srai_funct", 32'(o_funct), 32'(ALU_SRA));
        chk("srai_op_b", o_op_b, 32'd3);
        chk("srai_illegal", 32'(o_illegal), 32'd0);

        drive(1, 32'h4020D1B3, 32'h0, 32'h1234_5678, 32'hFFFF_FF21); // SRA x3,x1,x2
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("sra_funct", 32'(o_funct), 32'(ALU_SRA));
        chk("sra_op_b", o_op_b, 32'd1);

        drive(1, 32'h12345297, 32'h100, 32'hDEAD_BEEF, 32'h0);      // AUIPC x5,0x12345
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("auipc_funct", 32'(o_funct), 32'(ALU_ADD));
        chk("auipc_op_a", o_op_a, 32'h100);
        chk("auipc_op_b", o_op_b, 32'h1234_5000);

        drive(1, 32'h00100013, 32'h0, 32'h0, 32'h0);                // ADDI x0,x0,1
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("addi_x0_wr_en", 32'(o_wr_en), 32'd0);

        drive(1, 32'h0000006F, 32'h40, 32'h55, 32'h66);             // JAL: illegal here
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("jal_valid", 32'(o_valid), 32'd1);
        chk("jal_illegal", 32'(o_illegal), 32'd1);
        chk("jal_funct", 32'(o_funct), 32'(ALU_ADD));
        chk("jal_op_a", o_op_a, 32'd0);
        chk("jal_op_b", o_op_b, 32'd0);
        chk("jal_wr_en", 32'(o_wr_en), 32'd0);
        tick();
        tick();

        // Skid: A,B,C offered with downstream stalled.
        out_log.delete();
        i_ready = 1'b0;
        drive(1, 32'h002081B3, 32'h0, 32'hA, 32'h1);
        tick();
        drive(1, 32'h002081B3, 32'h0, 32'hB, 32'h2);
        tick();
        chk("skid_ready_low", 32'(o_ready), 32'd0);
        chk("skid_valid", 32'(o_valid), 32'd1);
        drive(1, 32'h002081B3, 32'h0, 32'hC, 32'h3);
        tick();
        tick();
        chk("skid_head_is_a", o_op_a, 32'hA);
        i_ready = 1'b1;
        for (int k = 0; k < 10 && i_valid; k++) begin
            tick();
            if (last_acc) i_valid = 1'b0;
        end
        chk("skid_c_accepted", 32'(i_valid), 32'd0);
        repeat (3) tick();
        chk("skid_out_count", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            chk("skid_order_0", out_log[0], 32'hA);
            chk("skid_order_1", out_log[1], 32'hB);
            chk("skid_order_2", out_log[2], 32'hC);
        end

        // Asynchronous reset with both entries full.
        i_ready = 1'b0;
        drive(1, 32'h00100093, 32'h0, 32'h11, 32'h0);
        tick();
        drive(1, 32'h00200113, 32'h0, 32'h22, 32'h0);
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("pre_rst_ready", 32'(o_ready), 32'd0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(o_valid), 32'd0);
        chk("async_rst_ready", 32'(o_ready), 32'd1);
        q.delete();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        repeat (4) tick();

        // Randomized traffic; a word is held upstream until accepted.
        for (int n = 0; n < 400; n++) begin
            if (!i_valid || last_acc)
                drive($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom, $urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) tick();
        chk("drain_empty", 32'(o_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Decode-and-issue pipeline stage directly upstream of the execute ALU in each core. Takes one RV32I instruction plus register-file read data and PC, decodes the ALU function, builds both operands (immediates, PC, masked shift amounts), and registers the result behind a valid/ready handshake with a 2-entry skid buffer. The ALU's funct and operand inputs connect straight to this stage's registered outputs.

## Interface
- DATA_SIZE, multicore_pkg::DATA_SIZE (32): operand/result width; only 32 is supported.

- i_clk  in  1  core clock, rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_valid  in  1  upstream has an instruction.
- o_ready  out  1  stage can accept; registered.
- i_instr  in  32  RV32I instruction word.
- i_pc  in  DATA_SIZE  PC of i_instr.
- i_rs1_data  in  DATA_SIZE  register-file read for rs1.
- i_rs2_data  in  DATA_SIZE  register-file read for rs2.
- o_valid  out  1  outputs hold an issued op.
- i_ready  in  1  downstream (ALU/writeback) accepts.
- o_funct  out  t_aluop  ALU function.
- o_op_a  out  DATA_SIZE  ALU operand A.
- o_op_b  out  DATA_SIZE  ALU operand B.
- o_rd  out  5  destination register.
- o_wr_en  out  1  result must be written back.
- o_illegal  out  1  instruction not decodable by this stage.

## Operation
- Transfer in: i_valid & o_ready. Transfer out: o_valid & i_ready.
- Supported opcodes:
  - OP (0110011): op_a=rs1; op_b=rs2. SLL/SRL/SRA use op_b={27'b0, rs2[4:0]}.
  - OP-IMM (0010011): op_a=rs1; op_b=sign-extended imm[31:20]. SLLI/SRLI/SRAI use op_b={27'b0, instr[24:20]}.
  - LUI (0110111): op_a=0; op_b={instr[31:12],12'b0}; ADD.
  - AUIPC (0010111): op_a=pc; op_b={instr[31:12],12'b0}; ADD.
- funct3 mapping: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- SUB and SRA select funct7=0100000. SRAI selects on instr[31:25]=0100000. SLTIU sign-extends the immediate; the ALU then compares unsigned.
- Illegal cases:
  - any other opcode;
  - OP with funct7 not 0000000, and not 0100000 on funct3 000/101;
  - OP-IMM shifts with instr[31:25] not 0000000, and not 0100000 on funct3 101.
- On an illegal instruction: o_illegal=1, o_funct=ADD, op_a=op_b=0, o_wr_en=0. The op still flows through the handshake.
- o_wr_en = legal & (rd != 0).

## Timing
- Latency 1 cycle: a word accepted at edge N is on the outputs after edge N with o_valid=1 (skid empty).
- Throughput 1/cycle while i_ready=1.
- Skid buffer holds two entries: a main (output) register and a skid register.
  - Accept while main is full and i_ready=0: word goes to skid; o_ready falls at the next edge.
  - Output transfer with skid full: skid moves to main; o_ready rises at the next edge.
  - Simultaneous input and output transfer with skid empty: main reloads from the input.
- o_ready = !skid_valid, registered. It never depends combinationally on i_ready.
- Order is strictly FIFO.
- Outputs are stable while o_valid & !i_ready.
- Reset values (asynchronous, any time, including mid-transfer):
  - o_valid=0, o_ready=1.
  - o_funct=ADD, o_op_a=0, o_op_b=0, o_rd=0, o_wr_en=0, o_illegal=0.
  - Both entries are discarded.
- First accept after reset deassertion is at the first rising edge with i_valid=1.

## Structure
- multicore_pkg holds DATA_SIZE, t_aluop, and the opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
- The package also holds an issue-payload struct t_alu_issue {funct, op_a, op_b, rd, wr_en, illegal}.
- Sub-module alu_decode: purely combinational instr/pc/rs data -> t_alu_issue.
- This module owns the two t_alu_issue registers and the handshake.

## Test plan
- ADD x3,x1,x2 with rs1=5, rs2=7, i_ready=1 -> next cycle o_valid=1, funct=ADD, op_a=5, op_b=7, rd=3, wr_en=1.
- SRAI x4,x1,3 (0x4030D213) with rs1=0x80000000 -> funct=SRA, op_b=3, illegal=0. SRA with rs2=0xFFFFFF21 -> op_b=1.
- AUIPC x5,0x12345 at pc=0x100 -> funct=ADD, op_a=0x100, op_b=0x12345000. ADDI x0,x0,1 -> wr_en=0.
- Opcode 0x0000006F (JAL) -> illegal=1, funct=ADD, op_a=op_b=0, wr_en=0, still delivered.
- Hold i_ready=0 and offer 3 back-to-back words A,B,C:
  - A and B are accepted; o_ready=0 one cycle after B; C is held upstream.
  - Release i_ready -> A, B, C emerge in order with no loss or duplication.
- Assert i_rst_n=0 mid-stream with both entries full -> o_valid=0 and o_ready=1 immediately (asynchronous); no old op appears after release.
